vga_sync_rx: RTL
================

VGA_SYNC_RX -- requirements
Module: vga_sync_rx

Interface
REQ-001 Parameter H_TOTAL, default 800: pclk cycles per line.
REQ-002 Parameter H_ACT_START, default 145: first active hcnt value (1-based).
REQ-003 Parameter H_ACT, default 640: active pixels per line.
REQ-004 Parameter V_TOTAL, default 525: lines per frame.
REQ-005 Parameter V_ACT_START, default 36: first active vcnt value (1-based).
REQ-006 Parameter V_ACT, default 480: active lines per frame.
REQ-007 pclk  input  1  pixel clock, all logic on rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 hsync_in  input  1  horizontal sync, active-low pulse.
REQ-010 vsync_in  input  1  vertical sync, active-low pulse.
REQ-011 rgb_in  input  24  pixel colour {R,G,B}, 8 bits each.
REQ-012 pix_valid  output  1  registered pixel strobe, active region and locked.
REQ-013 pix_x  output  10  column 0..H_ACT-1; 0 when pix_valid low.
REQ-014 pix_y  output  10  row 0..V_ACT-1; 0 when pix_valid low.
REQ-015 pix_data  output  24  rgb_in delayed to align with pix_valid.
REQ-016 frame_start  output  1  one-cycle pulse coincident with pix_valid at x=0,y=0.
REQ-017 locked  output  1  high in state LOCKED.
REQ-018 sync_err  output  1  one-cycle pulse on any line or frame length error.
REQ-019 err_cnt  output  8  error counter (see Configuration).

Function
REQ-020 hsync_in, vsync_in, rgb_in SHALL be registered once (stage S1); edges detected between S1 and its previous value.
REQ-021 hcnt (10 bit) SHALL load 1 on hsync fall, else increment, saturating at 1023.
REQ-022 At hsync fall, hcnt != H_TOTAL SHALL raise line error; first fall after reset exempt.
REQ-023 hcnt reaching 1023 SHALL raise one line error per saturation episode (lost hsync).
REQ-024 A vsync fall SHALL set a pending flag; flag cleared at the next hsync fall, same cycle included.
REQ-025 At hsync fall: pending flag set (or vsync fall same cycle) -> vcnt loads 1, frame boundary event; else vcnt increments, saturating at 1023.
REQ-026 At frame boundary, vcnt != V_TOTAL SHALL raise frame error; first boundary after reset exempt.
REQ-027 Lock FSM states UNLOCK, CHECK, LOCKED.
REQ-028 UNLOCK -> CHECK at a frame boundary with no error since previous boundary and vcnt == V_TOTAL.
REQ-029 CHECK -> LOCKED at next such clean boundary; CHECK -> UNLOCK on any error.
REQ-030 LOCKED -> UNLOCK in the cycle after any line or frame error; pix_valid drops the same cycle.
REQ-031 Active when V_ACT_START <= vcnt < V_ACT_START+V_ACT and H_ACT_START <= hcnt < H_ACT_START+H_ACT.
REQ-032 pix_x = hcnt-H_ACT_START, pix_y = vcnt-V_ACT_START, 10-bit unsigned, registered (stage S2).
REQ-033 Latency from input pins to pix_* SHALL be 2 pclk cycles; pix_data matches rgb_in of same pixel.
REQ-034 sync_err SHALL pulse one cycle, registered, one cycle after error detection; simultaneous line and frame error -> one pulse.

Reset
REQ-035 On reset: pix_valid, pix_x, pix_y, pix_data, frame_start, sync_err, locked = 0; FSM UNLOCK; hcnt, vcnt = 0; pending flag 0; exemption flags re-armed.
REQ-036 Reset mid-frame SHALL abort lock; relock requires two clean boundaries per REQ-028/029.

Configuration
REQ-037 Macro VGA_SYNC_RX_STATS_EN defined: err_cnt increments per sync_err pulse, saturates at 255, cleared only by reset.
REQ-038 Macro undefined: err_cnt tied to 0, no counter logic; all other behaviour identical.

Verification
REQ-039 Nominal 800x525 source (hsync low 96 clk, vsync low 2 lines) from reset -> locked rises at third frame boundary; 640 pix_valid per line, 480 lines per frame.
REQ-040 Locked; rgb_in = {x[7:0],y[7:0],8'hA5} -> pix_data matches pix_x/pix_y exactly, 2-cycle latency; frame_start once per frame.
REQ-041 Locked; one line of 799 clocks -> sync_err one pulse, locked low next cycle, err_cnt = 1 (STATS_EN); relock after 2 clean frames.
REQ-042 Locked; hsync held high 1100 clocks -> single sync_err at hcnt=1023, unlock.
REQ-043 Locked; frame of 524 lines -> frame error, unlock; vsync fall 10 clocks before hsync fall -> vcnt=1 at that hsync fall, no error.
REQ-044 Reset asserted mid-active-line -> all outputs 0 immediately (async); 300 forced errors with STATS_EN -> err_cnt = 255.

Source files
------------

// File: rtl/vga_sync_rx.sv
// VGA sync receiver: recovers line/frame timing from hsync/vsync, locks after two
// clean frame boundaries and emits aligned pixel coordinates and data.
// Optional macro VGA_SYNC_RX_STATS_EN enables the saturating sync error counter (err_cnt).
module vga_sync_rx #(
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned H_ACT_START = 145,
    parameter int unsigned H_ACT       = 640,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned V_ACT_START = 36,
    parameter int unsigned V_ACT       = 480
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [23:0] rgb_in,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [23:0] pix_data,
    output logic        frame_start,
    output logic        locked,
    output logic        sync_err,
    output logic [7:0]  err_cnt
);

    localparam logic [9:0]  LP_H_TOTAL   = 10'(H_TOTAL);
    localparam logic [9:0]  LP_V_TOTAL   = 10'(V_TOTAL);
    localparam logic [9:0]  LP_H_START   = 10'(H_ACT_START);
    localparam logic [9:0]  LP_V_START   = 10'(V_ACT_START);
    localparam logic [10:0] LP_H_END     = 11'(H_ACT_START + H_ACT);
    localparam logic [10:0] LP_V_END     = 11'(V_ACT_START + V_ACT);
    localparam logic [9:0]  LP_CNT_MAX   = 10'h3FF;

    typedef enum logic [1:0] {StUnlock, StCheck, StLocked} lock_state_t;

    lock_state_t r_state, w_state_nxt;

    logic        r_hs1, r_hs2, r_vs1, r_vs2;
    logic [23:0] r_rgb1;
    logic [9:0]  r_hcnt, r_vcnt;
    logic        r_vpend, r_harm, r_varm, r_err_seen;
    logic        r_pix_valid, r_frame_start, r_sync_err;
    logic [9:0]  r_pix_x, r_pix_y;
    logic [23:0] r_pix_data;

    logic        w_hfall, w_vfall, w_bound;
    logic [9:0]  w_hcnt, w_vcnt;
    logic        w_sat_err, w_len_err, w_line_err, w_frame_err, w_any_err, w_clean;
    logic        w_active, w_valid;
    logic [9:0]  w_pix_x, w_pix_y;

    assign w_hfall = r_hs2 & ~r_hs1;
    assign w_vfall = r_vs2 & ~r_vs1;

    // Stage S1: input capture plus previous sync levels for edge detection
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_hs1  <= 1'b1;
            r_hs2  <= 1'b1;
            r_vs1  <= 1'b1;
            r_vs2  <= 1'b1;
            r_rgb1 <= '0;
        end else begin
            r_hs1  <= hsync_in;
            r_hs2  <= r_hs1;
            r_vs1  <= vsync_in;
            r_vs2  <= r_vs1;
            r_rgb1 <= rgb_in;
        end
    end

    // Counter values for the pixel currently in S1, and error detection
    always_comb begin
        w_hcnt      = r_hcnt;
        w_vcnt      = r_vcnt;
        w_bound     = 1'b0;
        w_sat_err   = 1'b0;
        w_len_err   = 1'b0;
        w_frame_err = 1'b0;
        if (w_hfall) begin
            w_hcnt  = 10'd1;
            w_bound = r_vpend | w_vfall;
            // A saturated count was already reported when it hit the ceiling
            w_len_err = ~r_harm & (r_hcnt != LP_H_TOTAL) & (r_hcnt != LP_CNT_MAX);
            if (w_bound) begin
                w_vcnt      = 10'd1;
                w_frame_err = ~r_varm & (r_vcnt != LP_V_TOTAL);
            end else if (r_vcnt != LP_CNT_MAX) begin
                w_vcnt = r_vcnt + 10'd1;
            end
        end else if (r_hcnt != LP_CNT_MAX) begin
            w_hcnt    = r_hcnt + 10'd1;
            w_sat_err = (r_hcnt == LP_CNT_MAX - 10'd1);
        end
        w_line_err = w_len_err | w_sat_err;
        w_any_err  = w_line_err | w_frame_err;
        w_clean    = w_bound & ~w_any_err & ~r_err_seen & (r_vcnt == LP_V_TOTAL);
    end

    // Line/frame counters, vsync pending flag, first-event exemptions, error history
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_hcnt     <= '0;
            r_vcnt     <= '0;
            r_vpend    <= 1'b0;
            r_harm     <= 1'b1;
            r_varm     <= 1'b1;
            r_err_seen <= 1'b0;
        end else begin
            r_hcnt <= w_hcnt;
            r_vcnt <= w_vcnt;
            if (w_hfall) begin
                r_vpend <= 1'b0;
                r_harm  <= 1'b0;
            end else if (w_vfall) begin
                r_vpend <= 1'b1;
            end
            if (w_bound) begin
                r_varm     <= 1'b0;
                r_err_seen <= 1'b0;
            end else if (w_any_err) begin
                r_err_seen <= 1'b1;
            end
        end
    end

    // Lock FSM state register
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_state <= StUnlock;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Lock FSM next state: two consecutive clean boundaries are needed to lock
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StUnlock: if (w_clean) w_state_nxt = StCheck;
            StCheck: begin
                if (w_any_err)    w_state_nxt = StUnlock;
                else if (w_clean) w_state_nxt = StLocked;
            end
            StLocked: if (w_any_err) w_state_nxt = StUnlock;
            default:  w_state_nxt = StUnlock;
        endcase
    end

    // Active-window decode; uses next lock state so pix_valid drops with locked
    always_comb begin
        w_active = ({1'b0, w_hcnt} >= {1'b0, LP_H_START}) && ({1'b0, w_hcnt} < LP_H_END) &&
                   ({1'b0, w_vcnt} >= {1'b0, LP_V_START}) && ({1'b0, w_vcnt} < LP_V_END);
        w_valid  = w_active && (w_state_nxt == StLocked);
        w_pix_x  = '0;
        w_pix_y  = '0;
        if (w_valid) begin
            w_pix_x = w_hcnt - LP_H_START;
            w_pix_y = w_vcnt - LP_V_START;
        end
    end

    // Stage S2: registered pixel outputs and error pulse
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_pix_valid   <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_pix_data    <= '0;
            r_frame_start <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_pix_valid   <= w_valid;
            r_pix_x       <= w_pix_x;
            r_pix_y       <= w_pix_y;
            r_pix_data    <= r_rgb1;
            r_frame_start <= w_valid && (w_pix_x == '0) && (w_pix_y == '0);
            r_sync_err    <= w_any_err;
        end
    end

`ifdef VGA_SYNC_RX_STATS_EN
    logic [7:0] r_err_cnt;

    // Saturating count of sync_err pulses, updated alongside the pulse itself
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_err_cnt <= '0;
        end else if (w_any_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 8'h00;
`endif

    assign pix_valid   = r_pix_valid;
    assign pix_x       = r_pix_x;
    assign pix_y       = r_pix_y;
    assign pix_data    = r_pix_data;
    assign frame_start = r_frame_start;
    assign locked      = (r_state == StLocked);
    assign sync_err    = r_sync_err;

endmodule
